// File: rtl/ps2_key_decoder_pkg.sv
// Shared key codes, scan-code prefixes and the set-2 make-code map for the calculator front end.
// The operator block imports the same key constants.
package ps2_key_decoder_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_ENT = 4'd14;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RxIdle,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        PfxNorm,
        PfxExt,
        PfxBrk,
        PfxExtBrk
    } pfx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] key;
    } key_t;

    // Make code -> key value; hit=0 for anything that is not a calculator key.
    function automatic key_t decode_key(input logic [7:0] code, input logic ext);
        key_t k;
        k.hit = 1'b1;
        k.key = 4'd0;
        if (ext) begin
            case (code)
                8'h4A:   k.key = KEY_DIV;
                8'h5A:   k.key = KEY_ENT;
                default: k.hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h45, 8'h70: k.key = 4'd0;
                8'h16, 8'h69: k.key = 4'd1;
                8'h1E, 8'h72: k.key = 4'd2;
                8'h26, 8'h7A: k.key = 4'd3;
                8'h25, 8'h6B: k.key = 4'd4;
                8'h2E, 8'h73: k.key = 4'd5;
                8'h36, 8'h74: k.key = 4'd6;
                8'h3D, 8'h6C: k.key = 4'd7;
                8'h3E, 8'h75: k.key = 4'd8;
                8'h46, 8'h7D: k.key = 4'd9;
                8'h79:        k.key = KEY_ADD;
                8'h4E, 8'h7B: k.key = KEY_SUB;
                8'h7C:        k.key = KEY_MUL;
                8'h5A:        k.key = KEY_ENT;
                default:      k.hit = 1'b0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronises and deglitches the connector lines, shifts in one
// 11-bit frame, checks odd parity and stop bit, and drops partial frames on timeout.
module ps2_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    rx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    // A new ps2_clk level is accepted only after FILTER_LEN consecutive agreeing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == RxIdle || fall) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        case (state_q)
            RxIdle: begin
                if (fall && !data_sync_q) begin
                    state_d   = RxData;
                    bit_cnt_d = 3'd0;
                end
            end
            RxData: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RxParity;
                    end
                end
            end
            RxParity: begin
                if (fall) begin
                    par_ok_d = ^{shift_q, data_sync_q};
                    state_d  = RxStop;
                end
            end
            RxStop: begin
                if (fall) begin
                    state_d = RxIdle;
                    if (data_sync_q && par_ok_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = RxIdle;
        endcase

        // A falling edge in the same cycle keeps the frame alive.
        if (state_q != RxIdle && !fall && tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = RxIdle;
            frame_err_d = 1'b1;
            tmo_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            filt_q       <= 1'b1;
            filt_prev_q  <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= RxIdle;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            par_ok_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk;
            clk_sync_q   <= clk_meta_q;
            data_meta_q  <= ps2_data;
            data_sync_q  <= data_meta_q;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_q;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_ok_q     <= par_ok_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Calculator keyboard front end: tracks E0/F0 prefixes, maps make codes to key values
// and presents each key on data_out with a SEL_HOLD-cycle sel strobe.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned SEL_HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] data_out,
    output logic        sel,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned HW = $clog2(SEL_HOLD + 1);

    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          rx_err;

    pfx_state_e    pfx_q, pfx_d;
    key_t          dec;
    logic          key_hit;

    logic [10:0]   data_q, data_d;
    logic          sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          overrun_q, overrun_d;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (rx_err)
    );

    assign dec = decode_key(rx_byte, pfx_q == PfxExt);

    always_comb begin
        pfx_d   = pfx_q;
        key_hit = 1'b0;
        if (rx_err) begin
            pfx_d = PfxNorm;
        end else if (byte_valid) begin
            case (pfx_q)
                PfxNorm: begin
                    if (rx_byte == SC_EXT) begin
                        pfx_d = PfxExt;
                    end else if (rx_byte == SC_BRK) begin
                        pfx_d = PfxBrk;
                    end else begin
                        key_hit = dec.hit;
                    end
                end
                PfxExt: begin
                    if (rx_byte == SC_BRK) begin
                        pfx_d = PfxExtBrk;
                    end else begin
                        key_hit = dec.hit;
                        pfx_d   = PfxNorm;
                    end
                end
                // Release codes are swallowed whole.
                PfxBrk, PfxExtBrk: pfx_d = PfxNorm;
                default:           pfx_d = PfxNorm;
            endcase
        end
    end

    always_comb begin
        data_d    = data_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        overrun_d = 1'b0;
        if (sel_q) begin
            if (hold_q == '0) begin
                sel_d = 1'b0;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
        if (key_hit) begin
            if (sel_q) begin
                overrun_d = 1'b1;
            end else begin
                data_d = {7'd0, dec.key};
                sel_d  = 1'b1;
                hold_d = HW'(SEL_HOLD - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pfx_q     <= PfxNorm;
            data_q    <= 11'd0;
            sel_q     <= 1'b0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            pfx_q     <= pfx_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out  = data_q;
    assign sel       = sel_q;
    assign frame_err = rx_err;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of scan-code sequences plus hand-written
// sequences for parity, timeout, reset, glitch, latency and overrun.
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    logic [10:0] data_out, data_out2;
    logic        sel, sel2, frame_err, frame_err2, overrun, overrun2;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(5000),
        .SEL_HOLD   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_out (data_out),
        .sel      (sel),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    ps2_key_decoder #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(5000),
        .SEL_HOLD   (1000)
    ) dut_long (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_out (data_out2),
        .sel      (sel2),
        .frame_err(frame_err2),
        .overrun  (overrun2)
    );

    // bytes: byte j at [8j+:8]; keys: key k at [4k+:4]
    typedef struct packed {
        logic [3:0]  nb;
        logic [47:0] bytes;
        logic [3:0]  nk;
        logic [23:0] keys;
    } vec_t;

    vec_t vecs [10];

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int ovr2_cnt = 0;
    int keys2_cnt = 0;
    int sel_len = 0;
    int lat = 0;
    logic sel_prev = 1'b0;
    logic sel2_prev = 1'b0;
    logic [10:0] keyq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit track);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (track && sel && lat == 0) lat = i;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit((~^b) ^ bad_parity, 1'b0);
        lat = 0;
        ps2_bit(1'b1, 1'b1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Start bit plus four data bits of 0x1E, then the line goes quiet.
    task automatic send_partial();
        logic [7:0] b;
        b = 8'h1E;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                sel_len   = 0;
                sel_prev  = 1'b0;
                sel2_prev = 1'b0;
            end else begin
                if (frame_err) ferr_cnt++;
                if (overrun) ovr_cnt++;
                if (overrun2) ovr2_cnt++;
                if (sel && !sel_prev) keyq.push_back(data_out);
                if (sel2 && !sel2_prev) keys2_cnt++;
                if (sel) begin
                    sel_len++;
                end else if (sel_prev) begin
                    check("sel_hold_len", sel_len, 4);
                    sel_len = 0;
                end
                sel_prev  = sel;
                sel2_prev = sel2;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd3, 48'h00_00_00_16_F0_16, 4'd1, 24'h000001};
        vecs[1] = '{4'd6, 48'h5A_25_79_26_1E_16, 4'd6, 24'hE4A321};
        vecs[2] = '{4'd5, 48'h00_4A_F0_E0_4A_E0, 4'd1, 24'h00000D};
        vecs[3] = '{4'd2, 48'h00_00_00_00_5A_E0, 4'd1, 24'h00000E};
        vecs[4] = '{4'd4, 48'h00_00_7D_7A_69_70, 4'd4, 24'h009310};
        vecs[5] = '{4'd3, 48'h00_00_00_7C_4E_7B, 4'd3, 24'h000CBB};
        vecs[6] = '{4'd4, 48'h00_00_1C_77_14_E1, 4'd0, 24'h000000};
        vecs[7] = '{4'd3, 48'h00_00_00_45_16_E0, 4'd1, 24'h000000};
        vecs[8] = '{4'd3, 48'h00_00_00_3D_1E_F0, 4'd1, 24'h000007};
        vecs[9] = '{4'd4, 48'h00_00_46_3E_36_2E, 4'd4, 24'h009865};

        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_sel", sel, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            keyq.delete();
            ferr_cnt = 0;
            for (int j = 0; j < int'(vecs[i].nb); j++) send_frame(vecs[i].bytes[8*j +: 8], 1'b0);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_nkeys", i), keyq.size(), vecs[i].nk);
            for (int k = 0; k < int'(vecs[i].nk); k++)
                check($sformatf("vec%0d_key%0d", i, k), keyq[k], 32'(vecs[i].keys[4*k +: 4]));
            check($sformatf("vec%0d_frame_err", i), ferr_cnt, 0);
        end

        // Raw stop-bit fall -> sel: 2 sync + 8 filter + 2 pipeline cycles.
        send_frame(8'h3D, 1'b0);
        check("latency", lat, 12);
        check("latency_key", data_out, 7);

        // Bad parity: error pulse, no key, extended prefix forgotten.
        keyq.delete();
        ferr_cnt = 0;
        send_frame(8'h45, 1'b1);
        check("par_ferr", ferr_cnt, 1);
        check("par_nokey", keyq.size(), 0);
        check("par_hold", data_out, 7);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h12, 1'b1);
        send_frame(8'h4A, 1'b0);
        check("par_pfx_ferr", ferr_cnt, 2);
        check("par_pfx_nokey", keyq.size(), 0);
        send_frame(8'h45, 1'b0);
        check("par_recover_n", keyq.size(), 1);
        check("par_recover", data_out, 0);

        // Timeout on a stalled partial frame.
        ferr_cnt = 0;
        send_partial();
        repeat (4900) @(negedge clk);
        check("tmo_early", ferr_cnt, 0);
        repeat (200) @(negedge clk);
        check("tmo_ferr", ferr_cnt, 1);
        send_frame(8'h1E, 1'b0);
        check("tmo_recover", data_out, 2);

        // Reset in the middle of a frame, after an E0 prefix.
        send_frame(8'hE0, 1'b0);
        send_partial();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_data_out", data_out, 0);
        check("mrst_sel", sel, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        keyq.delete();
        ferr_cnt = 0;
        send_frame(8'h4A, 1'b0);
        check("mrst_pfx_cleared", keyq.size(), 0);
        send_frame(8'h26, 1'b0);
        check("mrst_recover", data_out, 3);
        check("mrst_ferr", ferr_cnt, 0);

        // Short ps2_clk glitches in IDLE must not start a frame.
        keyq.delete();
        ferr_cnt = 0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (7) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_nokey", keyq.size(), 0);
        send_frame(8'h45, 1'b0);
        check("glitch_nkeys", keyq.size(), 1);
        check("glitch_key", data_out, 0);
        check("glitch_ferr", ferr_cnt, 0);

        // Back-to-back keys while the long strobe is still high.
        repeat (1100) @(negedge clk);
        ovr_cnt = 0;
        ovr2_cnt = 0;
        keys2_cnt = 0;
        send_frame(8'h16, 1'b0);
        send_frame(8'h1E, 1'b0);
        repeat (20) @(negedge clk);
        check("ovr_pulse", ovr2_cnt, 1);
        check("ovr_keys", keys2_cnt, 1);
        check("ovr_data_kept", data_out2, 1);
        check("ovr_short_none", ovr_cnt, 0);
        check("ovr_short_data", data_out, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
